branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Fetch-side partner of the ID-stage branch resolver.
- In IF it predicts taken/not-taken and a target for the current PC, using a bimodal table of 2-bit counters and a direct-mapped BTB.
- It carries the prediction to ID in its own metadata register.
- When the resolver reports the branch outcome, the block trains the tables and flags a mispredict with the corrected redirect PC.

Parameters:
- DATA_WIDTH, 32, PC/target width.
- INDEX_BITS, 6, log2 of BHT/BTB entry count (64 entries).
- CNT_WIDTH, 32, width of the mispredict performance counter.

Ports:
- clk  in  1  core clock
- rstN  in  1  asynchronous active-low reset
- pcIF  in  DATA_WIDTH  PC of instruction in fetch
- stallID  in  1  hold IF->ID metadata register
- flushID  in  1  clear IF->ID metadata register (bubble)
- predTaken  out  1  IF prediction: redirect fetch
- predTarget  out  DATA_WIDTH  IF predicted target (valid when predTaken=1)
- resolveValid  in  1  ID holds a conditional branch this cycle (resolver branch=1)
- resolveTaken  in  1  resolver outcome (branchN)
- resolvePc  in  DATA_WIDTH  PC of the branch in ID
- resolveTarget  in  DATA_WIDTH  computed taken target in ID
- mispredict  out  1  ID prediction wrong; flush IF and redirect
- redirectPc  out  DATA_WIDTH  correct next PC when mispredict=1
- mispredictCount  out  CNT_WIDTH  saturating count of mispredicts

Behaviour:
- Reset (rstN=0, async):
  - all BHT counters = WEAK_NT (2'b01); all BTB valid bits = 0.
  - ID metadata predTakenID=0, predTargetID=0; mispredictCount=0.
  - Outputs predTaken=0, mispredict=0, redirectPc=0 while in reset.
- Indexing:
  - idx = pc[INDEX_BITS+1:2].
  - tag = pc[DATA_WIDTH-1:INDEX_BITS+2].
- Lookup is combinational, 0-cycle, from registered table state.
  - predTaken = BTB valid[idx] & tag match & BHT[idx][1].
  - predTarget = BTB target[idx] when predTaken, else 0.
- IF->ID metadata register:
  - Update order per clk: flushID sets (0,0); else stallID holds; else captures (predTaken, predTarget).
  - flushID has priority over stallID.
- Mispredict (combinational, qualified by resolveValid):
  - mispredict = resolveValid & ( (resolveTaken != predTakenID) | (resolveTaken & predTakenID & resolveTarget != predTargetID) ).
  - redirectPc = resolveTaken ? resolveTarget : resolvePc+4 (mod 2^DATA_WIDTH); 0 when mispredict=0.
- Training, on posedge clk when resolveValid=1 and stallID=0:
  - BHT[idx(resolvePc)] saturates: taken increments (max STRONG_T), not-taken decrements (min STRONG_NT).
  - If resolveTaken: BTB[idx] is written valid=1, tag, target=resolveTarget; otherwise BTB is unchanged.
  - stallID=1 blocks training, so the same branch is never trained twice.
- Simultaneous lookup and training on the same index: lookup returns the pre-update value; the new value is visible next cycle. No bypass.
- mispredictCount: +1 on each clk with mispredict=1 & stallID=0; saturates at all-ones.
- Reset asserted mid-operation clears everything immediately; the first cycle after release behaves as post-reset.
- resolveValid=0 causes no training and no mispredict, regardless of resolveTaken.

Decomposition:
- definitions package: typedef enum logic[1:0] bhtState_t {STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11}; reset constant BHT_INIT=WEAK_NT.
- One sub-module, btb_array: valid/tag/target storage with one combinational read port, one synchronous write port and async-reset valid clear.
- The BHT and the control logic stay in the top module.

Test Plan:
- Reset state: reset, then pcIF=0x100 -> predTaken=0, predTarget=0, mispredictCount=0.
- Cold taken branch then warm prediction:
  - Resolve pc=0x100, taken, target=0x80, with predTakenID=0 -> mispredict=1, redirectPc=0x80.
  - Next cycle, pcIF=0x100 -> predTaken=1 (counter WEAK_T), predTarget=0x80.
- Saturation and hysteresis:
  - Train 0x100 taken 3 times (counter STRONG_T), then not-taken once -> predTaken remains 1.
  - Second not-taken -> predTaken=0.
- Not-taken fallthrough: predicted-taken branch at 0x1FC resolves not-taken -> mispredict=1, redirectPc=0x200. Wrap case: resolvePc=0xFFFFFFFC -> redirectPc=0x0.
- Aliasing and target change:
  - 0x100 and 0x200 share idx; train 0x100 taken, then lookup 0x200 -> predTaken=0 (tag miss).
  - Resolve 0x100 taken with target 0x90 while predTargetID=0x80 -> mispredict=1, redirectPc=0x90.
- Stall/flush:
  - stallID=1 for 3 cycles with resolveValid=1 -> no counter change and mispredictCount increments 0 times.
  - flushID=1 with stallID=1 -> predTakenID=0.
  - Same-index lookup during training returns the old value.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor: 2-bit BHT counter states
// and their saturating update.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bhtState_t;

  localparam bhtState_t BHT_INIT = WEAK_NT;

  function automatic bhtState_t bht_next(input bhtState_t s, input logic taken);
    bhtState_t n;
    n = s;
    case (s)
      STRONG_NT: n = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   n = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    n = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  n = taken ? STRONG_T : WEAK_T;
      default:   n = s;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/decode-side signal bundle for the branch predictor; the core side is the
// master, the predictor is the slave.
interface branch_predictor_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic [DATA_WIDTH-1:0] pcIF;
  logic                  stallID;
  logic                  flushID;
  logic                  predTaken;
  logic [DATA_WIDTH-1:0] predTarget;
  logic                  resolveValid;
  logic                  resolveTaken;
  logic [DATA_WIDTH-1:0] resolvePc;
  logic [DATA_WIDTH-1:0] resolveTarget;
  logic                  mispredict;
  logic [DATA_WIDTH-1:0] redirectPc;
  logic [CNT_WIDTH-1:0]  mispredictCount;

  modport master (
    output pcIF, stallID, flushID, resolveValid, resolveTaken, resolvePc, resolveTarget,
    input  predTaken, predTarget, mispredict, redirectPc, mispredictCount
  );

  modport slave (
    input  pcIF, stallID, flushID, resolveValid, resolveTaken, resolvePc, resolveTarget,
    output predTaken, predTarget, mispredict, redirectPc, mispredictCount
  );
endinterface

// File: rtl/branch_predictor_btb_array.sv
// Direct-mapped BTB storage: combinational read, synchronous write; only the valid
// bits are reset, tag/target contents are meaningless until their entry is written.
module branch_predictor_btb_array #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int TAG_W      = 24
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [INDEX_BITS-1:0] i_rdIdx,
  output logic                  o_rdValid,
  output logic [TAG_W-1:0]      o_rdTag,
  output logic [DATA_WIDTH-1:0] o_rdTarget,
  input  logic                  i_wrEn,
  input  logic [INDEX_BITS-1:0] i_wrIdx,
  input  logic [TAG_W-1:0]      i_wrTag,
  input  logic [DATA_WIDTH-1:0] i_wrTarget
);
  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]    r_valid;
  logic [TAG_W-1:0]      r_tag    [ENTRIES];
  logic [DATA_WIDTH-1:0] r_target [ENTRIES];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)       r_valid          <= '0;
    else if (i_wrEn) r_valid[i_wrIdx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_tag[i_wrIdx]    <= i_wrTag;
      r_target[i_wrIdx] <= i_wrTarget;
    end
  end

  assign o_rdValid  = r_valid[i_rdIdx];
  assign o_rdTag    = r_tag[i_rdIdx];
  assign o_rdTarget = r_target[i_rdIdx];
endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with BTB: predicts in IF, carries the prediction to ID,
// trains on the resolver outcome and flags mispredicts with the corrected PC.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int CNT_WIDTH  = 32
) (
  input  logic              clk,
  input  logic              rstN,
  branch_predictor_if.slave bp
);
  localparam int TAG_W   = DATA_WIDTH - INDEX_BITS - 2;
  localparam int ENTRIES = 1 << INDEX_BITS;

  bhtState_t             r_bht [ENTRIES];
  logic                  r_predTakenID;
  logic [DATA_WIDTH-1:0] r_predTargetID;
  logic [CNT_WIDTH-1:0]  r_mispredictCount;

  logic [INDEX_BITS-1:0] w_ifIdx, w_idIdx;
  logic [TAG_W-1:0]      w_ifTag, w_idTag, w_btbTag;
  logic                  w_btbValid, w_predTaken, w_mispredict, w_train, w_btbWr;
  logic [DATA_WIDTH-1:0] w_btbTarget, w_predTarget, w_fallthrough;
  logic                  w_unused;

  assign w_ifIdx  = bp.pcIF[INDEX_BITS+1:2];
  assign w_ifTag  = bp.pcIF[DATA_WIDTH-1:INDEX_BITS+2];
  assign w_idIdx  = bp.resolvePc[INDEX_BITS+1:2];
  assign w_idTag  = bp.resolvePc[DATA_WIDTH-1:INDEX_BITS+2];
  assign w_unused = ^{bp.pcIF[1:0], bp.resolvePc[1:0]};

  // A stalled ID stage keeps the same branch, so it must not be trained again.
  assign w_train = bp.resolveValid & ~bp.stallID;
  assign w_btbWr = w_train & bp.resolveTaken;

  branch_predictor_btb_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_btb (
    .clk        (clk),
    .rstN       (rstN),
    .i_rdIdx    (w_ifIdx),
    .o_rdValid  (w_btbValid),
    .o_rdTag    (w_btbTag),
    .o_rdTarget (w_btbTarget),
    .i_wrEn     (w_btbWr),
    .i_wrIdx    (w_idIdx),
    .i_wrTag    (w_idTag),
    .i_wrTarget (bp.resolveTarget)
  );

  // IF lookup: registered table state only, so a same-index update shows next cycle.
  assign w_predTaken  = rstN & w_btbValid & (w_btbTag == w_ifTag) & r_bht[w_ifIdx][1];
  assign w_predTarget = w_predTaken ? w_btbTarget : '0;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < ENTRIES; i++) r_bht[i] <= BHT_INIT;
    end else if (w_train) begin
      r_bht[w_idIdx] <= bht_next(r_bht[w_idIdx], bp.resolveTaken);
    end
  end

  // IF -> ID boundary: flush wins over stall.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_predTakenID  <= 1'b0;
      r_predTargetID <= '0;
    end else if (bp.flushID) begin
      r_predTakenID  <= 1'b0;
      r_predTargetID <= '0;
    end else if (!bp.stallID) begin
      r_predTakenID  <= w_predTaken;
      r_predTargetID <= w_predTarget;
    end
  end

  assign w_mispredict = rstN & bp.resolveValid &
                        ((bp.resolveTaken != r_predTakenID) |
                         (bp.resolveTaken & r_predTakenID & (bp.resolveTarget != r_predTargetID)));
  assign w_fallthrough = bp.resolvePc + DATA_WIDTH'(4);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)
      r_mispredictCount <= '0;
    else if (w_mispredict && !bp.stallID && (r_mispredictCount != '1))
      r_mispredictCount <= r_mispredictCount + 1'b1;
  end

  assign bp.predTaken       = w_predTaken;
  assign bp.predTarget      = w_predTarget;
  assign bp.mispredict      = w_mispredict;
  assign bp.redirectPc      = w_mispredict ? (bp.resolveTaken ? bp.resolveTarget : w_fallthrough) : '0;
  assign bp.mispredictCount = r_mispredictCount;
endmodule
